// File: rtl/tx_link_ctrl.sv
// TX-side link controller: brings the link up after debounce, handles far-end
// pause and retransmit requests, and re-inits on sustained RX errors.
// Optional macro: RIFL_RETRANS_EN builds the retransmission path.
module tx_link_ctrl #(
    parameter int unsigned UP_DEBOUNCE = 64,
    parameter int unsigned PAUSE_MIN   = 8,
    parameter int unsigned ERR_LIMIT   = 16
) (
    input  logic       tx_frame_clk,
    input  logic       rst_n,
    input  logic       pause_req_tx,
    input  logic       retrans_req_tx,
    input  logic       rx_aligned_tx,
    input  logic       rx_up_tx,
    input  logic       rx_error_tx,
    input  logic       tx_retrans_ack,
    output logic       link_up,
    output logic       tx_pause,
    output logic       retrans_start,
    output logic       retrans_busy,
    output logic       relink_req,
    output logic [2:0] link_state
);

    localparam int unsigned DBC_W  = $clog2(UP_DEBOUNCE + 1);
    localparam int unsigned PCNT_W = $clog2(PAUSE_MIN + 1);
    localparam int unsigned ERR_W  = $clog2(ERR_LIMIT + 1);

    localparam logic [DBC_W-1:0]  DBC_LAST   = DBC_W'(UP_DEBOUNCE - 1);
    localparam logic [PCNT_W-1:0] PAUSE_LAST = PCNT_W'(PAUSE_MIN - 1);
    localparam logic [PCNT_W-1:0] PAUSE_MAX  = {PCNT_W{1'b1}};
    localparam logic [ERR_W-1:0]  ERR_MAX    = ERR_W'(ERR_LIMIT);
    localparam logic [ERR_W-1:0]  ERR_HIT_AT = ERR_W'(ERR_LIMIT - 1);

    typedef enum logic [2:0] {
        ST_DOWN     = 3'd0,
        ST_ALIGN    = 3'd1,
        ST_DEBOUNCE = 3'd2,
        ST_UP       = 3'd3,
        ST_PAUSE    = 3'd4,
        ST_RETRANS  = 3'd5
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [DBC_W-1:0]   dbc_cnt_r;
    logic [PCNT_W-1:0]  pause_cnt_r;
    logic [ERR_W-1:0]   err_cnt_r;

    logic link_active_s;
    logic link_lost_s;
    logic err_hit_s;
    logic retrans_edge_s;
    logic retrans_ack_s;
    logic pending_s;
    logic pend_any_s;
    logic start_next_s;
    logic relink_next_s;
    logic take_pend_s;
    logic link_up_next_s;
    logic tx_pause_next_s;
    logic busy_next_s;

    function automatic logic [PCNT_W-1:0] pause_inc(input logic [PCNT_W-1:0] v);
        if (v == PAUSE_MAX) begin
            return v;
        end else begin
            return v + PCNT_W'(1);
        end
    endfunction

    function automatic logic [ERR_W-1:0] err_inc(input logic [ERR_W-1:0] v);
        if (v == ERR_MAX) begin
            return v;
        end else begin
            return v + ERR_W'(1);
        end
    endfunction

    assign link_active_s = (state_r == ST_UP) || (state_r == ST_PAUSE) || (state_r == ST_RETRANS);
    assign link_lost_s   = ~rx_aligned_tx | ~rx_up_tx;
    // The error that would bring the run length to ERR_LIMIT triggers the relink on the same edge.
    assign err_hit_s     = rx_error_tx & (err_cnt_r >= ERR_HIT_AT);
    assign pend_any_s    = pending_s | retrans_edge_s;
    assign link_state    = state_r;

`ifdef RIFL_RETRANS_EN
    logic retrans_d_r;
    logic pending_r;

    assign retrans_edge_s = retrans_req_tx & ~retrans_d_r;
    assign retrans_ack_s  = tx_retrans_ack;
    assign pending_s      = pending_r;

    // Edge history and the retransmit request parked while pausing.
    always_ff @(posedge tx_frame_clk or negedge rst_n) begin
        if (!rst_n) begin
            retrans_d_r <= 1'b0;
            pending_r   <= 1'b0;
        end else begin
            retrans_d_r <= retrans_req_tx;
            if (state_next_s == ST_DOWN) begin
                pending_r <= 1'b0;
            end else if (take_pend_s) begin
                pending_r <= 1'b0;
            end else if ((state_r == ST_PAUSE) && retrans_edge_s) begin
                pending_r <= 1'b1;
            end else begin
                pending_r <= pending_r;
            end
        end
    end

    // Replay handshake outputs.
    always_ff @(posedge tx_frame_clk or negedge rst_n) begin
        if (!rst_n) begin
            retrans_start <= 1'b0;
            retrans_busy  <= 1'b0;
        end else begin
            retrans_start <= start_next_s;
            retrans_busy  <= busy_next_s;
        end
    end
`else
    logic unused_retrans_s;

    assign retrans_edge_s   = 1'b0;
    assign retrans_ack_s    = 1'b0;
    assign pending_s        = 1'b0;
    assign retrans_start    = 1'b0;
    assign retrans_busy     = 1'b0;
    assign unused_retrans_s = ^{retrans_req_tx, tx_retrans_ack, take_pend_s, start_next_s, busy_next_s};
`endif

    // State register.
    always_ff @(posedge tx_frame_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_DOWN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; loss of lanes outranks the error relink, which outranks everything else.
    always_comb begin
        state_next_s  = state_r;
        start_next_s  = 1'b0;
        relink_next_s = 1'b0;
        take_pend_s   = 1'b0;
        case (state_r)
            ST_DOWN: begin
                if (rx_aligned_tx) begin
                    state_next_s = ST_ALIGN;
                end else begin
                    state_next_s = ST_DOWN;
                end
            end
            ST_ALIGN: begin
                if (!rx_aligned_tx) begin
                    state_next_s = ST_DOWN;
                end else if (rx_up_tx) begin
                    state_next_s = ST_DEBOUNCE;
                end else begin
                    state_next_s = ST_ALIGN;
                end
            end
            ST_DEBOUNCE: begin
                if (!rx_aligned_tx) begin
                    state_next_s = ST_DOWN;
                end else if (!rx_up_tx) begin
                    state_next_s = ST_ALIGN;
                end else if (dbc_cnt_r == DBC_LAST) begin
                    state_next_s = ST_UP;
                end else begin
                    state_next_s = ST_DEBOUNCE;
                end
            end
            ST_UP: begin
                if (link_lost_s) begin
                    state_next_s = ST_DOWN;
                end else if (err_hit_s) begin
                    state_next_s  = ST_DOWN;
                    relink_next_s = 1'b1;
                end else if (retrans_edge_s) begin
                    state_next_s = ST_RETRANS;
                    start_next_s = 1'b1;
                end else if (pause_req_tx) begin
                    state_next_s = ST_PAUSE;
                end else begin
                    state_next_s = ST_UP;
                end
            end
            ST_PAUSE: begin
                if (link_lost_s) begin
                    state_next_s = ST_DOWN;
                end else if (err_hit_s) begin
                    state_next_s  = ST_DOWN;
                    relink_next_s = 1'b1;
                end else if (!pause_req_tx && (pause_cnt_r >= PAUSE_LAST)) begin
                    if (pend_any_s) begin
                        state_next_s = ST_RETRANS;
                        start_next_s = 1'b1;
                        take_pend_s  = 1'b1;
                    end else begin
                        state_next_s = ST_UP;
                    end
                end else begin
                    state_next_s = ST_PAUSE;
                end
            end
            ST_RETRANS: begin
                if (link_lost_s) begin
                    state_next_s = ST_DOWN;
                end else if (err_hit_s) begin
                    state_next_s  = ST_DOWN;
                    relink_next_s = 1'b1;
                end else if (retrans_ack_s) begin
                    if (pause_req_tx) begin
                        state_next_s = ST_PAUSE;
                    end else begin
                        state_next_s = ST_UP;
                    end
                end else begin
                    state_next_s = ST_RETRANS;
                end
            end
            default: begin
                state_next_s = ST_DOWN;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs line up with link_state.
    always_comb begin
        link_up_next_s  = 1'b0;
        tx_pause_next_s = 1'b0;
        busy_next_s     = 1'b0;
        case (state_next_s)
            ST_UP: begin
                link_up_next_s = 1'b1;
            end
            ST_PAUSE: begin
                link_up_next_s  = 1'b1;
                tx_pause_next_s = 1'b1;
            end
            ST_RETRANS: begin
                link_up_next_s = 1'b1;
                busy_next_s    = 1'b1;
            end
            default: begin
                link_up_next_s = 1'b0;
            end
        endcase
    end

    // Registered link outputs.
    always_ff @(posedge tx_frame_clk or negedge rst_n) begin
        if (!rst_n) begin
            link_up    <= 1'b0;
            tx_pause   <= 1'b0;
            relink_req <= 1'b0;
        end else begin
            link_up    <= link_up_next_s;
            tx_pause   <= tx_pause_next_s;
            relink_req <= relink_next_s;
        end
    end

    // Debounce, pause-dwell and error-run counters; each idles at zero outside its states.
    always_ff @(posedge tx_frame_clk or negedge rst_n) begin
        if (!rst_n) begin
            dbc_cnt_r   <= '0;
            pause_cnt_r <= '0;
            err_cnt_r   <= '0;
        end else begin
            if (state_r == ST_DEBOUNCE) begin
                dbc_cnt_r <= dbc_cnt_r + DBC_W'(1);
            end else begin
                dbc_cnt_r <= '0;
            end
            if (state_r == ST_PAUSE) begin
                pause_cnt_r <= pause_inc(pause_cnt_r);
            end else begin
                pause_cnt_r <= '0;
            end
            if (link_active_s && rx_error_tx) begin
                err_cnt_r <= err_inc(err_cnt_r);
            end else begin
                err_cnt_r <= '0;
            end
        end
    end

endmodule

// File: tb/tb_tx_link_ctrl.sv
// Self-checking bench for tx_link_ctrl: a cycle-level reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_tx_link_ctrl;

    localparam int UP_DEBOUNCE = 64;
    localparam int PAUSE_MIN   = 8;
    localparam int ERR_LIMIT   = 16;
`ifdef RIFL_RETRANS_EN
    localparam bit RETRANS_ON = 1'b1;
`else
    localparam bit RETRANS_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pause_req = 1'b0;
    logic retrans_req = 1'b0;
    logic aligned = 1'b0;
    logic rx_up = 1'b0;
    logic rx_error = 1'b0;
    logic ack = 1'b0;
    logic link_up, tx_pause, retrans_start, retrans_busy, relink_req;
    logic [2:0] link_state;

    int n_checks = 0;
    int n_pass = 0;

    tx_link_ctrl #(.UP_DEBOUNCE(UP_DEBOUNCE), .PAUSE_MIN(PAUSE_MIN), .ERR_LIMIT(ERR_LIMIT)) dut (
        .tx_frame_clk  (clk),
        .rst_n         (rst_n),
        .pause_req_tx  (pause_req),
        .retrans_req_tx(retrans_req),
        .rx_aligned_tx (aligned),
        .rx_up_tx      (rx_up),
        .rx_error_tx   (rx_error),
        .tx_retrans_ack(ack),
        .link_up       (link_up),
        .tx_pause      (tx_pause),
        .retrans_start (retrans_start),
        .retrans_busy  (retrans_busy),
        .relink_req    (relink_req),
        .link_state    (link_state)
    );

    always #5 clk = ~clk;

    // Reference model: state plus "cycles spent in this state" and error run length.
    int m_state, m_dcyc, m_pcyc, m_errs, ns, errs_now;
    bit m_pend, m_prev, edge_seen;
    bit m_link, m_txp, m_start, m_busy, m_relink;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_dcyc = 0; m_pcyc = 0; m_errs = 0;
            m_pend = 0; m_prev = 0;
            m_link = 0; m_txp = 0; m_start = 0; m_busy = 0; m_relink = 0;
        end else begin
            edge_seen = RETRANS_ON && retrans_req && !m_prev;
            m_prev = RETRANS_ON && retrans_req;
            ns = m_state;
            m_start = 0;
            m_relink = 0;
            if (m_state >= 3) begin
                errs_now = rx_error ? m_errs + 1 : 0;
                if (!aligned || !rx_up) ns = 0;
                else if (errs_now >= ERR_LIMIT) begin ns = 0; m_relink = 1; end
                else if (m_state == 3) begin
                    if (edge_seen) begin ns = 5; m_start = 1; end
                    else if (pause_req) ns = 4;
                end else if (m_state == 4) begin
                    if (edge_seen) m_pend = 1;
                    if (!pause_req && (m_pcyc + 1 >= PAUSE_MIN)) begin
                        if (m_pend) begin ns = 5; m_start = 1; m_pend = 0; end
                        else ns = 3;
                    end
                end else begin
                    if (RETRANS_ON && ack) ns = pause_req ? 4 : 3;
                end
                m_errs = errs_now;
            end else begin
                m_errs = 0;
                if (m_state == 0) begin
                    if (aligned) ns = 1;
                end else if (m_state == 1) begin
                    if (!aligned) ns = 0;
                    else if (rx_up) ns = 2;
                end else begin
                    if (!aligned) ns = 0;
                    else if (!rx_up) ns = 1;
                    else if (m_dcyc + 1 == UP_DEBOUNCE) ns = 3;
                end
            end
            m_dcyc = (ns == 2 && m_state == 2) ? m_dcyc + 1 : 0;
            m_pcyc = (ns == 4 && m_state == 4) ? m_pcyc + 1 : 0;
            if (ns == 0) m_pend = 0;
            m_state = ns;
            m_link = (ns >= 3);
            m_txp = (ns == 4);
            m_busy = (ns == 5);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        n_checks++;
        if (link_state === 3'(m_state) && link_up === m_link && tx_pause === m_txp &&
            retrans_start === m_start && retrans_busy === m_busy && relink_req === m_relink) begin
            n_pass++;
        end else begin
            $display("FAIL model_cmp t=%0t got st=%0d lu=%0b tp=%0b rs=%0b rb=%0b rr=%0b expected st=%0d lu=%0b tp=%0b rs=%0b rb=%0b rr=%0b",
                     $time, link_state, link_up, tx_pause, retrans_start, retrans_busy, relink_req,
                     m_state, m_link, m_txp, m_start, m_busy, m_relink);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_up(input string name);
        int k;
        k = 0;
        while (!link_up && k < 300) begin cyc(1); k++; end
        chk(name, int'(link_up), 1);
    endtask

    int n, hi, rl, at, st, lu, rs, rb;

    initial begin
        cyc(3);
        chk("reset_state", int'(link_state), 0);
        chk("reset_link_up", int'(link_up), 0);
        rst_n = 1'b1;
        cyc(2);
        chk("down_idle", int'(link_state), 0);

        // Bring-up with a one-cycle rx_up drop at debounce count 30.
        aligned = 1'b1; cyc(1);
        chk("to_align", int'(link_state), 1);
        rx_up = 1'b1; cyc(1);
        chk("to_debounce", int'(link_state), 2);
        cyc(30);
        rx_up = 1'b0; cyc(1);
        chk("debounce_drop_state", int'(link_state), 1);
        chk("debounce_drop_link", int'(link_up), 0);
        rx_up = 1'b1; cyc(1);
        chk("re_debounce", int'(link_state), 2);
        n = 0;
        while (!link_up && n < 200) begin cyc(1); n++; end
        chk("debounce_len", n, 64);
        chk("up_state", int'(link_state), 3);

        // Two-cycle pause request gives the minimum eight-cycle pause.
        pause_req = 1'b1; cyc(1);
        chk("pause_entry", int'(link_state), 4);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 1) pause_req = 1'b0;
            hi += int'(tx_pause);
            cyc(1);
        end
        chk("pause_len", hi, 8);
        chk("pause_exit", int'(link_state), 3);

        // Fifteen error cycles are tolerated.
        rl = 0; rx_error = 1'b1;
        for (int i = 0; i < 15; i++) begin cyc(1); rl += int'(relink_req); end
        rx_error = 1'b0;
        for (int i = 0; i < 5; i++) begin cyc(1); rl += int'(relink_req); end
        chk("err15_relink", rl, 0);
        chk("err15_state", int'(link_state), 3);

        // Sixteen error cycles force a relink.
        rl = 0; at = 0; st = 9; lu = 9; rx_error = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            cyc(1);
            if (relink_req) begin rl++; at = i; st = int'(link_state); lu = int'(link_up); end
        end
        rx_error = 1'b0;
        chk("err16_pulses", rl, 1);
        chk("err16_at", at, 16);
        chk("err16_state", st, 0);
        chk("err16_link", lu, 0);
        wait_up("relink_recover");

`ifdef RIFL_RETRANS_EN
        // Retransmit edge and pause in the same cycle: retransmit wins.
        pause_req = 1'b1; retrans_req = 1'b1; cyc(1);
        chk("rt_state", int'(link_state), 5);
        chk("rt_start", int'(retrans_start), 1);
        cyc(1);
        chk("rt_start_pulse", int'(retrans_start), 0);
        chk("rt_busy", int'(retrans_busy), 1);
        retrans_req = 1'b0; cyc(1);
        retrans_req = 1'b1; cyc(1);
        chk("rt_ignore_edge", int'(retrans_start), 0);
        ack = 1'b1; cyc(1); ack = 1'b0;
        chk("rt_ack_pause", int'(link_state), 4);
        chk("rt_ack_busy", int'(retrans_busy), 0);

        // Edge while paused is held and taken on exit.
        retrans_req = 1'b0; cyc(1);
        retrans_req = 1'b1; cyc(1);
        pause_req = 1'b0;
        n = 0;
        while (link_state != 3'd5 && n < 40) begin cyc(1); n++; end
        chk("rt_pending_state", int'(link_state), 5);
        chk("rt_pending_start", int'(retrans_start), 1);

        // Reset mid-replay aborts silently.
        cyc(2);
        rst_n = 1'b0; #1;
        chk("rt_rst_state", int'(link_state), 0);
        chk("rt_rst_busy", int'(retrans_busy), 0);
        chk("rt_rst_link", int'(link_up), 0);
        retrans_req = 1'b0;
        cyc(2);
        rst_n = 1'b1; cyc(1);
        chk("rt_rst_restart", int'(link_state), 1);
        wait_up("rt_rst_recover");

        // Ack outside RETRANS does nothing.
        ack = 1'b1; cyc(1); ack = 1'b0; cyc(1);
        chk("ack_ignored", int'(link_state), 3);
`else
        // Retransmit inputs have no effect in this build.
        rs = 0; rb = 0;
        for (int i = 0; i < 12; i++) begin
            retrans_req = (i % 2 == 1);
            ack = (i == 5);
            cyc(1);
            rs += int'(retrans_start);
            rb += int'(retrans_busy);
        end
        retrans_req = 1'b0; ack = 1'b0;
        chk("noretx_state", int'(link_state), 3);
        chk("noretx_start", rs, 0);
        chk("noretx_busy", rb, 0);
`endif

        // Reset mid-pause aborts and restarts from DOWN.
        pause_req = 1'b1; cyc(3);
        chk("pause_before_rst", int'(link_state), 4);
        rst_n = 1'b0; #1;
        chk("pause_rst_state", int'(link_state), 0);
        chk("pause_rst_txp", int'(tx_pause), 0);
        chk("pause_rst_link", int'(link_up), 0);
        pause_req = 1'b0;
        cyc(2);
        rst_n = 1'b1; cyc(1);
        chk("pause_rst_restart", int'(link_state), 1);
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
